// File: rtl/alu_muldiv_ctrl.sv
// alu_muldiv_ctrl: RV32I ALU select decode plus a handshaked, iterative RV32M multiply/divide engine.
module alu_muldiv_ctrl #(
  parameter int XLEN = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [3:0]      alu_op,
  output logic            is_md,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] md_result
);
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_SRL = 4'd9;
  localparam logic [3:0] ALU_COPY_B = 4'd10;
  localparam int CW = $clog2(XLEN);
  localparam logic EO = EARLY_OUT != 0;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_n;
  logic [2*XLEN-1:0] p, p_n, full;
  logic [XLEN-1:0] b_r, ma, mb, sel, fin, early_res;
  logic [XLEN:0] mul_sum, r_sh, diff;
  logic [CW-1:0] cnt;
  logic [2:0] f3_r;
  logic neg_r, sa, sb, neg, dz, ovf, early, accept, busy;

  assign is_md = (opcode == OPC_ARI_RTYPE) && (funct7 == 7'b0000001);

  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OPC_LUI) alu_op = ALU_COPY_B;
    else if ((opcode == OPC_ARI_RTYPE && !is_md) || opcode == OPC_ARI_ITYPE)
      case (funct3)
        3'd0: alu_op = (opcode == OPC_ARI_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'd1: alu_op = ALU_SLL;
        3'd2: alu_op = ALU_SLT;
        3'd3: alu_op = ALU_SLTU;
        3'd4: alu_op = ALU_XOR;
        3'd5: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
        3'd6: alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
  end

  assign busy = (state == MUL) || (state == DIV);
  assign out_valid = state == DONE;
  assign in_ready = (state == IDLE) || (state == DONE && out_ready);
  assign accept = in_valid && in_ready && is_md && !flush;

  // Operand signedness: MULHU and the unsigned divides treat both operands as unsigned, MULHSU only rs2.
  assign sa = op_a[XLEN-1] & (funct3[2] ? !funct3[0] : funct3[1:0] != 2'd3);
  assign sb = op_b[XLEN-1] & (funct3[2] ? !funct3[0] : !funct3[1]);
  assign dz = op_b == '0;
  assign ovf = funct3[2] && !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && &op_b;
  // Quotient of x/0 must stay all ones, so the sign fix-up is suppressed for a zero divisor.
  assign neg = funct3[2] ? (funct3[1] ? sa : (sa ^ sb) && !dz) : sa ^ sb;
  assign ma = sa ? -op_a : op_a;
  assign mb = sb ? -op_b : op_b;
  assign early = EO && funct3[2] && (dz || ovf);
  assign early_res = dz ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);

  // p holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, b_r} : '0);
  assign r_sh = {p[2*XLEN-1:XLEN], p[XLEN-1]};
  assign diff = r_sh - {1'b0, b_r};
  assign p_n = (state == MUL) ? {mul_sum, p[XLEN-1:1]}
             : diff[XLEN] ? {r_sh[XLEN-1:0], p[XLEN-2:0], 1'b0}
             : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
  assign full = neg_r ? -p_n : p_n;
  assign sel = f3_r[1] ? p_n[2*XLEN-1:XLEN] : p_n[XLEN-1:0];
  assign fin = f3_r[2] ? (neg_r ? -sel : sel)
             : (f3_r[1:0] == 2'd0) ? full[XLEN-1:0] : full[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (accept) state_n = early ? DONE : (funct3[2] ? DIV : MUL);
    else if (busy) state_n = (cnt == '0) ? DONE : state;
    else if (state == DONE && out_ready) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      p <= '0;
      b_r <= '0;
      f3_r <= '0;
      neg_r <= 1'b0;
      cnt <= '0;
      md_result <= '0;
    end else if (flush) begin
      cnt <= '0;
      md_result <= '0;
    end else if (accept) begin
      p <= {{XLEN{1'b0}}, funct3[2] ? ma : mb};
      b_r <= funct3[2] ? mb : ma;
      f3_r <= funct3;
      neg_r <= neg;
      cnt <= CW'(XLEN - 1);
      if (early) md_result <= early_res;
    end else if (busy) begin
      p <= p_n;
      cnt <= cnt - CW'(1);
      if (cnt == '0) md_result <= fin;
    end
endmodule
